// File: rtl/nios_simple_st_pkg.sv
// nios_simple_st_pkg: width helpers and error-bit indices shared by the ST timing adapter
package nios_simple_st_pkg;
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_W = 2;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int empty_w(input int data_w, input int symbol_w);
    return (clog2(data_w / symbol_w) > 1) ? clog2(data_w / symbol_w) : 1;
  endfunction
  function automatic int payload_w(input int data_w, input int symbol_w);
    return data_w + 2 + empty_w(data_w, symbol_w);
  endfunction
endpackage

// File: rtl/nios_simple_st_fifo.sv
// nios_simple_st_fifo: show-ahead register FIFO with compare-wrapped pointers and fill level
module nios_simple_st_fifo
  import nios_simple_st_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int FILL_W = clog2(DEPTH + 1),
  localparam int PTR_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [FILL_W-1:0] fill_level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic full, push, pop;
  assign full = fill_level == FILL_W'(DEPTH);
  assign rd_valid = fill_level != '0;
  assign pop = rd_valid & rd_en;
  assign push = wr_en & (!full | pop);
  // payload reads as zero while empty so idle/reset outputs are clean
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // pointers and fill count; a push while full without a pop is discarded
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      if (push != pop) fill_level <= push ? fill_level + 1'b1 : fill_level - 1'b1;
    end
  // storage array, no reset needed since reads are gated by rd_valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/nios_simple_st_timing_adapter.sv
// nios_simple_st_timing_adapter: absorbs upstream ready latency, presents a latency-0 Avalon-ST stream (NIOS_SIMPLE_ST_ADAPTER_ERR_EN adds sticky error port)
module nios_simple_st_timing_adapter
  import nios_simple_st_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SYMBOL_W = 8,
  parameter int DEPTH = 8,
  parameter int IN_READY_LATENCY = 1,
  localparam int EMPTY_W = empty_w(DATA_W, SYMBOL_W),
  localparam int FILL_W = clog2(DEPTH + 1),
  localparam int PAYLOAD_W = payload_w(DATA_W, SYMBOL_W)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [FILL_W-1:0]  fill_level
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
  ,
  output logic [ERR_W-1:0]   error
`endif
);
  logic wr_en;
  logic [PAYLOAD_W-1:0] rd_payload;
  // headroom of L entries covers the beats already in flight when ready drops
  assign in_ready = !reset && (fill_level < FILL_W'(DEPTH - IN_READY_LATENCY));
  assign wr_en = (IN_READY_LATENCY == 0) ? (in_valid & in_ready) : in_valid;
  assign {out_data, out_startofpacket, out_endofpacket, out_empty} = rd_payload;
  nios_simple_st_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data({in_data, in_startofpacket, in_endofpacket, in_empty}),
    .rd_en(out_ready),
    .rd_data(rd_payload),
    .rd_valid(out_valid),
    .fill_level(fill_level)
  );
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
  logic in_pkt, overflow, framing_err;
  assign overflow = wr_en & (fill_level == FILL_W'(DEPTH)) & !(out_valid & out_ready);
  // SOP must match "not inside a packet": SOP in open packet or non-SOP outside both flag
  assign framing_err = wr_en & (in_startofpacket == in_pkt);
  // sticky error flags and open-packet tracking, cleared only by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_pkt <= 1'b0;
      error <= '0;
    end else begin
      if (wr_en) in_pkt <= !in_endofpacket;
      if (overflow) error[ERR_OVERFLOW] <= 1'b1;
      if (framing_err) error[ERR_FRAMING] <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_nios_simple_st_timing_adapter.sv
// tb_nios_simple_st_timing_adapter: scoreboard and table-driven bench over three adapter configurations
module tb_nios_simple_st_timing_adapter;
  typedef struct packed {logic [31:0] d; logic s; logic e; logic [1:0] em;} beat_t;
  typedef struct {logic v; logic [31:0] d; logic s; logic e; logic [1:0] em; logic r; int fl;} vec_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_sop = 0, in_eop = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic [1:0] in_empty = '0;
  logic [2:0] ir, ov, osop, oeop;
  logic [31:0] od [3];
  logic [1:0] oem [3];
  logic [3:0] fl0;
  logic [1:0] fl1;
  logic [2:0] fl2;
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
  logic [1:0] err [3];
`endif
  int checks = 0, failures = 0, sel = 0, dep = 8, lat = 1, popped = 0;
  beat_t q[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  nios_simple_st_timing_adapter #(.DEPTH(8), .IN_READY_LATENCY(1)) u0 (
    .clk(clk), .reset(rst), .in_ready(ir[0]), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(ov[0]), .out_data(od[0]), .out_startofpacket(osop[0]), .out_endofpacket(oeop[0]),
    .out_empty(oem[0]), .fill_level(fl0)
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    , .error(err[0])
`endif
  );
  nios_simple_st_timing_adapter #(.DEPTH(2), .IN_READY_LATENCY(0)) u1 (
    .clk(clk), .reset(rst), .in_ready(ir[1]), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(ov[1]), .out_data(od[1]), .out_startofpacket(osop[1]), .out_endofpacket(oeop[1]),
    .out_empty(oem[1]), .fill_level(fl1)
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    , .error(err[1])
`endif
  );
  nios_simple_st_timing_adapter #(.DEPTH(5), .IN_READY_LATENCY(1)) u2 (
    .clk(clk), .reset(rst), .in_ready(ir[2]), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(ov[2]), .out_data(od[2]), .out_startofpacket(osop[2]), .out_endofpacket(oeop[2]),
    .out_empty(oem[2]), .fill_level(fl2)
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    , .error(err[2])
`endif
  );
  function automatic int cur_fl();
    return sel == 0 ? int'(fl0) : sel == 1 ? int'(fl1) : int'(fl2);
  endfunction
  function automatic beat_t cur_beat();
    beat_t b;
    b = {od[sel], osop[sel], oeop[sel], oem[sel]};
    return b;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // one cycle: drive inputs, check state against the model, update the scoreboard, advance
  task automatic cyc(input logic v, input logic [31:0] d, input logic s, input logic e,
                     input logic [1:0] em, input logic r);
    beat_t nb;
    bit pop, acc;
    int n;
    in_valid = v; in_data = d; in_sop = s; in_eop = e; in_empty = em; out_ready = r;
    n = q.size();
    chk("fill_level", cur_fl(), n);
    chk("in_ready", ir[sel], n < dep - lat);
    chk("out_valid", ov[sel], n != 0);
    pop = (n != 0) && r;
    if (pop) begin
      chk("beat", cur_beat(), q.pop_front());
      popped++;
    end
    acc = v && (lat != 0 || n < dep);
    nb = {d, s, e, em};
    if (acc && (n < dep || pop)) q.push_back(nb);
    @(posedge clk); #1;
  endtask
  task automatic do_reset(input int s);
    sel = s;
    dep = s == 0 ? 8 : s == 1 ? 2 : 5;
    lat = s == 1 ? 0 : 1;
    rst = 1; in_valid = 0; out_ready = 0; in_sop = 0; in_eop = 0; in_data = '0; in_empty = '0;
    @(posedge clk); #1;
    chk("rst_in_ready", ir[sel], 0);
    chk("rst_out_valid", ov[sel], 0);
    chk("rst_fill", cur_fl(), 0);
    chk("rst_payload", cur_beat(), 0);
    rst = 0;
    q.delete();
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int sent, base;
    logic pir, v;
    tbl[0] = '{1'b1, 32'hA0, 1'b1, 1'b0, 2'd0, 1'b0, 0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 2'd0, 1'b0, 1};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 2'd2, 1'b0, 2};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 3};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 2};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 0};
    // fill DEPTH=8, L=1 with out_ready low from a legal upstream
    do_reset(0);
    sent = 0; pir = 0;
    for (int i = 0; i < 14; i++) begin
      v = pir;
      pir = ir[0];
      cyc(v, 32'(sent + 1), 1'b0, 1'b0, 2'd0, 1'b0);
      if (v) sent++;
    end
    chk("t1_sent", sent, 8);
    chk("t1_fill", fl0, 8);
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    chk("t1_no_overflow", err[0][0], 0);
`endif
    // drain in order, one per cycle
    base = popped;
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("t2_popped", popped - base, 8);
    chk("t2_out_valid", ov[0], 0);
    chk("t2_fill", fl0, 0);
    // L=0, DEPTH=2 continuous flow
    do_reset(1);
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      v = q.size() < 2;
      cyc(1'b1, 32'h50 + 32'(sent), 1'b0, 1'b0, 2'd0, 1'b1);
      if (v) sent++;
    end
    chk("t3_sent", sent, 10);
    chk("t3_fill", fl1, 1);
    // packet framing through the table
    do_reset(0);
    for (int i = 0; i < 7; i++) begin
      chk("tbl_fill", fl0, 64'(tbl[i].fl));
      cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].em, tbl[i].r);
    end
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    chk("t4_no_error", err[0], 2'b00);
`endif
    // DEPTH=5 wrap with random backpressure
    do_reset(2);
    sent = 0; pir = 0; base = popped;
    for (int i = 0; i < 300 && (sent < 12 || q.size() != 0); i++) begin
      v = pir && sent < 12;
      pir = ir[2];
      cyc(v, 32'h100 + 32'(sent), 1'b0, 1'b0, 2'd0, 1'($urandom_range(0, 1)));
      if (v) sent++;
    end
    chk("t5_sent", sent, 12);
    chk("t5_popped", popped - base, 12);
    chk("t5_fill", fl2, 0);
    // reset mid-packet discards stored beats asynchronously
    do_reset(0);
    cyc(1'b1, 32'hC0, 1'b1, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 32'hC1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("t6_fill_before", fl0, 2);
    in_valid = 0;
    #3 rst = 1;
    #1;
    chk("t6_async_out_valid", ov[0], 0);
    chk("t6_async_fill", fl0, 0);
    chk("t6_in_ready", ir[0], 0);
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    #1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    // flood while full: excess beats dropped, first eight kept in order
    do_reset(0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b1, 2'd1, 1'b0);
    chk("t7_fill", fl0, 8);
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    chk("t7_overflow", err[0], 2'b01);
`endif
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("t7_drained", fl0, 0);
`ifdef NIOS_SIMPLE_ST_ADAPTER_ERR_EN
    chk("t7_sticky", err[0], 2'b01);
    do_reset(0);
    chk("t8_err_cleared", err[0], 2'b00);
    cyc(1'b1, 32'h300, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("t8_framing", err[0], 2'b10);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
